pool_unit: RTL

Parametrised streaming pooling engine for the CNN datapath, sitting between the convolution/ReLU stage and the layer output buffer. It reduces each window of 2^k consecutive signed samples to one result, either the maximum or the arithmetic mean (sum shifted right by k). Input and output use valid/ready handshakes, and the result is held in a one-entry output register. Unlike the previous fixed max-pool, the first sample of each window seeds the running value, so all-negative windows pool correctly.

---
 rtl/pool_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pool_unit.sv
// Streaming pooling engine: reduces each window of 2^k signed samples to its
// maximum or its floor-mean, with valid/ready on both sides and a one-entry output register.
module pool_unit #(
  parameter int DATA_W = 32,
  parameter int KMAX   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       mode,
  input  logic [$clog2(KMAX+1)-1:0]  win_k,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       busy
);

  localparam int KW = $clog2(KMAX + 1);
  localparam int AW = DATA_W + KMAX;
  localparam int CW = KMAX + 1;
  localparam logic [KW-1:0] K_LIMIT = KW'(KMAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                   state_r, state_s;
  logic [CW-1:0]            cnt_r, cnt_s;
  logic signed [AW-1:0]     acc_r, acc_s;
  logic                     mode_r, mode_s;
  logic [KW-1:0]            k_r, k_s;
  logic                     out_valid_r, out_valid_s;
  logic [DATA_W-1:0]        out_data_r, out_data_s;

  logic                     cur_mode_s;
  logic [KW-1:0]            cur_k_s;
  logic signed [AW-1:0]     sample_s;
  logic signed [AW-1:0]     acc_next_s;
  logic                     final_s;
  logic                     in_ready_s;
  logic                     accept_s;
  logic                     drain_s;

  // Datapath: window parameters in force, next accumulator value and handshake decode.
  always_comb begin
    cur_mode_s = mode_r;
    cur_k_s    = k_r;
    case (state_r)
      IDLE: begin
        cur_mode_s = mode;
        cur_k_s    = (win_k > K_LIMIT) ? K_LIMIT : win_k;
      end
      ACC: begin
        cur_mode_s = mode_r;
        cur_k_s    = k_r;
      end
      default: begin
        cur_mode_s = mode_r;
        cur_k_s    = k_r;
      end
    endcase

    sample_s = {{KMAX{in_data[DATA_W-1]}}, in_data};
    // The first sample seeds the running value so all-negative windows pool correctly.
    if (state_r == IDLE) begin
      acc_next_s = sample_s;
    end else if (cur_mode_s) begin
      acc_next_s = acc_r + sample_s;
    end else if (sample_s > acc_r) begin
      acc_next_s = sample_s;
    end else begin
      acc_next_s = acc_r;
    end

    final_s    = ((cnt_r + CNT_ONE) == (CNT_ONE << cur_k_s));
    in_ready_s = !(in_valid && final_s) || !out_valid_r || out_ready;
    accept_s   = in_valid && in_ready_s;
    drain_s    = out_valid_r && out_ready;
  end

  // FSM next state and register updates; clear overrides any accept or drain.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    acc_s       = acc_r;
    mode_s      = mode_r;
    k_s         = k_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    if (clear) begin
      state_s     = IDLE;
      cnt_s       = {CW{1'b0}};
      out_valid_s = 1'b0;
    end else begin
      if (accept_s && (state_r == IDLE)) begin
        mode_s = cur_mode_s;
        k_s    = cur_k_s;
      end else begin
        mode_s = mode_r;
        k_s    = k_r;
      end
      if (accept_s && final_s) begin
        state_s     = IDLE;
        cnt_s       = {CW{1'b0}};
        acc_s       = acc_next_s;
        out_valid_s = 1'b1;
        out_data_s  = cur_mode_s ? DATA_W'(acc_next_s >>> cur_k_s) : DATA_W'(acc_next_s);
      end else if (accept_s) begin
        state_s = ACC;
        cnt_s   = cnt_r + CNT_ONE;
        acc_s   = acc_next_s;
        if (drain_s) begin
          out_valid_s = 1'b0;
        end else begin
          out_valid_s = out_valid_r;
        end
      end else if (drain_s) begin
        out_valid_s = 1'b0;
      end else begin
        out_valid_s = out_valid_r;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {AW{1'b0}};
      mode_r      <= 1'b0;
      k_r         <= {KW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      mode_r      <= mode_s;
      k_r         <= k_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = (state_r == ACC);

endmodule
